// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Owner encodings, master ids and the read-tag bundle.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic owner_e owner_of(input logic id);
        return id ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with lock override.
// Purely combinational; the caller masks the result during reset.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  owner_e     lock_owner,
    input  logic       lock_expired,
    output logic [1:0] gnt
);

    // Lock owner first, then sole requester, then the master not served last.
    always_comb begin
        gnt = 2'b00;
        if (lock_owner == OWN_M0 && req[0] && !lock_expired) begin
            gnt = 2'b01;
        end else if (lock_owner == OWN_M1 && req[1] && !lock_expired) begin
            gnt = 2'b10;
        end else begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the core data side (m0)
// and the debug/loader engine (m1); routes 1-cycle read data back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic         m0_wr,
    input  logic [N-1:0] m0_addr,
    input  logic [N-1:0] m0_wdata,
    input  logic         m0_lock,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    output logic [N-1:0] m0_rdata,
    input  logic         m1_req,
    input  logic         m1_wr,
    input  logic [N-1:0] m1_addr,
    input  logic [N-1:0] m1_wdata,
    input  logic         m1_lock,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [N-1:0] m1_rdata,
    output logic         mem_wr_ena,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_rd_data
);

    logic       last_gnt;
    owner_e     lock_owner;
    logic [7:0] lock_cnt;
    rd_tag_t    rd_tag;

    logic [1:0] arb_gnt;
    logic [1:0] gnt;
    logic       lock_expired;
    logic       any_gnt;
    logic       gnt_id;
    logic       sel_wr;
    logic       sel_lock;
    logic       owner_req;

    assign lock_expired = (lock_cnt >= 8'(MAX_LOCK));

    rr_arb2 u_arb (
        .req          ({m1_req, m0_req}),
        .last_gnt     (last_gnt),
        .lock_owner   (lock_owner),
        .lock_expired (lock_expired),
        .gnt          (arb_gnt)
    );

    // No grant may escape while reset is held.
    assign gnt     = rst ? 2'b00 : arb_gnt;
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign any_gnt = |gnt;
    assign gnt_id  = gnt[1];

    assign owner_req = (lock_owner == OWN_M0 && m0_req) ||
                       (lock_owner == OWN_M1 && m1_req);

    // Steer the granted master onto the memory port; idle port drives zeros.
    always_comb begin
        mem_wr_ena  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        sel_wr      = 1'b0;
        sel_lock    = 1'b0;
        if (gnt[0]) begin
            mem_wr_ena  = m0_wr;
            mem_addr    = m0_addr;
            mem_wr_data = m0_wdata;
            sel_wr      = m0_wr;
            sel_lock    = m0_lock;
        end else if (gnt[1]) begin
            mem_wr_ena  = m1_wr;
            mem_addr    = m1_addr;
            mem_wr_data = m1_wdata;
            sel_wr      = m1_wr;
            sel_lock    = m1_lock;
        end
    end

    // Arbitration history, lock window and in-flight read tag.
    // A lock re-granted after expiry starts a fresh window of MAX_LOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt     <= ID_M1;
            lock_owner   <= OWN_NONE;
            lock_cnt     <= 8'd0;
            rd_tag.valid <= 1'b0;
            rd_tag.id    <= ID_M0;
        end else begin
            rd_tag.valid <= any_gnt && !sel_wr;
            rd_tag.id    <= gnt_id;
            if (any_gnt) begin
                last_gnt <= gnt_id;
                if (!sel_lock) begin
                    lock_owner <= OWN_NONE;
                    lock_cnt   <= 8'd0;
                end else if (lock_owner == owner_of(gnt_id) && !lock_expired) begin
                    lock_cnt <= lock_cnt + 8'd1;
                end else begin
                    lock_owner <= owner_of(gnt_id);
                    lock_cnt   <= 8'd1;
                end
            end else if (lock_owner != OWN_NONE && !owner_req) begin
                lock_owner <= OWN_NONE;
                lock_cnt   <= 8'd0;
            end
        end
    end

    assign m0_rvalid = rd_tag.valid && (rd_tag.id == ID_M0);
    assign m1_rvalid = rd_tag.valid && (rd_tag.id == ID_M1);
    assign m0_rdata  = mem_rd_data;
    assign m1_rdata  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, expected grant tables,
// and a read-return scoreboard fed from a shadow copy of memory.
module tb_mem_port_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_req, m0_wr, m0_lock;
    logic [N-1:0] m0_addr, m0_wdata;
    logic         m0_gnt, m0_rvalid;
    logic [N-1:0] m0_rdata;
    logic         m1_req, m1_wr, m1_lock;
    logic [N-1:0] m1_addr, m1_wdata;
    logic         m1_gnt, m1_rvalid;
    logic [N-1:0] m1_rdata;
    logic         mem_wr_ena;
    logic [N-1:0] mem_addr, mem_wr_data;
    logic [N-1:0] mem_rd_data;

    typedef struct {
        logic        valid;
        logic        id;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mem[256];
    bit          written[256];
    logic [31:0] shadow[256];
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .MAX_LOCK(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    function automatic logic [31:0] init_val(input int a);
        return 32'hC0DE_0000 | (a * 7);
    endfunction

    // Synchronous memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_ena) begin
            mem[mem_addr[7:0]]     <= mem_wr_data;
            written[mem_addr[7:0]] <= 1'b1;
        end
        mem_rd_data <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                             : init_val(int'(mem_addr[7:0]));
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: check last cycle's read return, this cycle's grant and
    // port drive, push this cycle's read expectation, then advance.
    task automatic tick(input logic [1:0] eg, input string tag);
        sb_t e;
        logic        w;
        logic [31:0] a, d;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rv0"}, 32'(m0_rvalid), 32'(e.valid && e.id == 1'b0));
            chk({tag, "_rv1"}, 32'(m1_rvalid), 32'(e.valid && e.id == 1'b1));
            if (e.valid)
                chk({tag, "_rd"}, e.id ? m1_rdata : m0_rdata, e.data);
        end
        chk({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'(eg));
        e.valid = 1'b0;
        e.id    = 1'b0;
        e.data  = '0;
        if (eg != 2'b00) begin
            e.id = eg[1];
            w = e.id ? m1_wr : m0_wr;
            a = e.id ? m1_addr : m0_addr;
            d = e.id ? m1_wdata : m0_wdata;
            chk({tag, "_addr"}, mem_addr, a);
            chk({tag, "_we"}, 32'(mem_wr_ena), 32'(w));
            if (w) begin
                chk({tag, "_wd"}, mem_wr_data, d);
                shadow[a[7:0]] = d;
            end else begin
                e.valid = 1'b1;
                e.data  = shadow[a[7:0]];
            end
        end else begin
            chk({tag, "_idle"}, 32'({mem_wr_ena, mem_addr[30:0]}), 32'd0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        rst = 1'b1;
        {m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock} = '0;
        m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_rv", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone m0 read.
        m0_req = 1'b1; m0_addr = 32'h10;
        tick(2'b01, "s1");
        m0_req = 1'b0;
        tick(2'b00, "s1i");

        // Both masters hold reads: strict alternation starting at m0.
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h30;
        m1_req = 1'b1; m1_addr = 32'h41;
        for (int i = 0; i < 6; i++)
            tick((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("alt%0d", i));
        m0_req = 1'b0; m1_req = 1'b0;
        tick(2'b00, "alti");

        // m1 write, then m0 reads it back.
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
        tick(2'b10, "wr");
        m1_req = 1'b0; m1_wr = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h20;
        tick(2'b01, "raw");
        m0_req = 1'b0;
        tick(2'b00, "rawi");
        chk("raw_shadow", shadow[8'h20], 32'hDEADBEEF);

        // Bounded lock: 8 m0 grants, one m1, then m0 re-locks.
        do_reset();
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h50;
        m1_req = 1'b1; m1_addr = 32'h60;
        for (int i = 0; i < 8; i++) tick(2'b01, $sformatf("lk%0d", i));
        tick(2'b10, "lkbrk");
        for (int i = 0; i < 3; i++) tick(2'b01, $sformatf("lkr%0d", i));

        // Owner drops req: m1 wins at once and the lock window restarts.
        m0_req = 1'b0;
        tick(2'b10, "drop");
        m0_req = 1'b1;
        for (int i = 0; i < 8; i++) tick(2'b01, $sformatf("rl%0d", i));
        tick(2'b10, "rlbrk");
        m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;
        tick(2'b00, "rli");

        // Reset lands while an m1 read is in flight.
        m1_req = 1'b1; m1_addr = 32'h70;
        @(negedge clk);
        chk("rf_g1", 32'(m1_gnt), 32'd1);
        sb.delete();
        #1;
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h11;
        @(negedge clk);
        chk("rf_rv1", 32'(m1_rvalid), 32'd0);
        chk("rf_rv0", 32'(m0_rvalid), 32'd0);
        chk("rf_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2'b01, "rft0");
        tick(2'b10, "rft1");
        m0_req = 1'b0; m1_req = 1'b0;
        tick(2'b00, "rfti");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
